// File: rtl/lzy_scan138_keypad_pkg.sv
// Shared types and helpers for the 8-line scan decoder keypad.
package lzy_scan_pkg;

    localparam int unsigned NLINES = 8;
    localparam int unsigned AW     = 3;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        PRESENT = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // Active-low one-hot line select for address a.
    function automatic logic [NLINES-1:0] onehot_n(input logic [AW-1:0] a);
        return ~(NLINES'(1) << a);
    endfunction

endpackage

// File: rtl/lzy_scan138_keypad_if.sv
// Key-code handshake between the scanner (master) and its consumer (slave).
interface lzy_scan138_keypad_if;
    import lzy_scan_pkg::*;

    logic [AW-1:0] code;
    logic          valid;
    logic          ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/lzy_scan138_keypad_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV enabled cycles, holds when disabled.
module lzy_tick_gen #(
    parameter int unsigned DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_c
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick_c = en_i && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lzy_scan138_keypad.sv
// 74HC138-style descending line scanner with debounced key-index capture and valid/ready output.
module lzy_scan138_keypad
    import lzy_scan_pkg::*;
#(
    parameter int unsigned DIV      = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ei_n_i,
    input  logic                 sense_n_i,
    output logic [NLINES-1:0]    y_n_o,
    output logic [AW-1:0]        a_o,
    output logic                 gs_n_o,
    lzy_scan138_keypad_if.master kp
);
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE);

    state_e            state_q, state_d;
    logic [AW-1:0]     a_q, a_d;
    logic [AW-1:0]     code_q, code_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic [NLINES-1:0] y_n_q, y_n_d;
    logic              valid_q, valid_d;
    logic              gs_n_q, gs_n_d;
    logic              tick;

    lzy_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (!ei_n_i),
        .tick_c (tick)
    );

    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            a_q     <= AW'(NLINES - 1);
            code_q  <= '0;
            cnt_q   <= '0;
            y_n_q   <= '1;
            valid_q <= 1'b0;
            gs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            y_n_q   <= y_n_d;
            valid_q <= valid_d;
            gs_n_q  <= gs_n_d;
        end
    end

    // Next state; disable forces SCAN from anywhere.
    always_comb begin
        state_d = state_q;
        if (ei_n_i) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                SCAN:    if (tick && !sense_n_i) state_d = (DEBOUNCE == 1) ? PRESENT : CONFIRM;
                CONFIRM: if (tick) begin
                             if (sense_n_i)          state_d = SCAN;
                             else if (cnt_inc == DB) state_d = PRESENT;
                         end
                PRESENT: if (kp.ready) state_d = RELEASE;
                RELEASE: if (tick && sense_n_i && cnt_inc == DB) state_d = SCAN;
                default: state_d = SCAN;
            endcase
        end
    end

    // Datapath and registered outputs; A only moves when a line is left behind in SCAN.
    always_comb begin
        a_d     = a_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (ei_n_i) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SCAN, CONFIRM: if (tick) begin
                    if (sense_n_i) begin
                        a_d = a_q - AW'(1);
                    end else begin
                        cnt_d = (state_q == SCAN) ? CW'(1) : cnt_inc;
                        if (state_d == PRESENT) begin
                            code_d  = a_q;
                            valid_d = 1'b1;
                        end
                    end
                end
                PRESENT: if (kp.ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end
                RELEASE: if (tick) begin
                    if (sense_n_i) begin
                        cnt_d = cnt_inc;
                        if (state_d == SCAN) a_d = a_q - AW'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
        gs_n_d = (state_d == SCAN);
        y_n_d  = ei_n_i ? '1 : onehot_n(a_q);
    end

    assign y_n_o    = y_n_q;
    assign a_o      = a_q;
    assign gs_n_o   = gs_n_q;
    assign kp.code  = code_q;
    assign kp.valid = valid_q;
endmodule

// File: tb/tb_lzy_scan138_keypad.sv
// Bench for the scan keypad: directed key sequences, scoreboard on the code handshake.
module tb_lzy_scan138_keypad;
    import lzy_scan_pkg::*;

    logic       clk;
    logic       rst_n0, rst_n1, ei_n0, ei_n1;
    logic [7:0] y0, y1;
    logic [2:0] a0, a1;
    logic       gs0, gs1, sense0, sense1;
    int         key0, key1;
    int         n_run, n_fail;
    logic [2:0] q0[$];
    logic [2:0] q1[$];

    lzy_scan138_keypad_if kp0();
    lzy_scan138_keypad_if kp1();

    lzy_scan138_keypad #(.DIV(4), .DEBOUNCE(3)) u0 (
        .clk(clk), .rst_n(rst_n0), .ei_n_i(ei_n0), .sense_n_i(sense0),
        .y_n_o(y0), .a_o(a0), .gs_n_o(gs0), .kp(kp0));

    lzy_scan138_keypad #(.DIV(1), .DEBOUNCE(1)) u1 (
        .clk(clk), .rst_n(rst_n1), .ei_n_i(ei_n1), .sense_n_i(sense1),
        .y_n_o(y1), .a_o(a1), .gs_n_o(gs1), .kp(kp1));

    // Key matrix: the return line is low when the scanned line's key is closed.
    assign sense0 = !(key0 >= 0 && int'(a0) == key0);
    assign sense1 = !(key1 >= 0 && int'(a1) == key1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic       pv0, pv1;
        logic [2:0] pc0, pc1;
        pv0 = 1'b0; pv1 = 1'b0; pc0 = '0; pc1 = '0;
        forever begin
            @(negedge clk);
            #3;
            if (kp0.valid && pv0) chk("code_hold0", 32'(kp0.code), 32'(pc0));
            if (kp1.valid && pv1) chk("code_hold1", 32'(kp1.code), 32'(pc1));
            if (kp0.valid && kp0.ready) begin
                if (q0.size() == 0) begin
                    n_run++; n_fail++;
                    $display("FAIL sb_code0: unexpected code %0d, none expected", kp0.code);
                end else chk("sb_code0", 32'(kp0.code), 32'(q0.pop_front()));
            end
            if (kp1.valid && kp1.ready) begin
                if (q1.size() == 0) begin
                    n_run++; n_fail++;
                    $display("FAIL sb_code1: unexpected code %0d, none expected", kp1.code);
                end else chk("sb_code1", 32'(kp1.code), 32'(q1.pop_front()));
            end
            pv0 = kp0.valid; pc0 = kp0.code;
            pv1 = kp1.valid; pc1 = kp1.code;
        end
    endtask

    initial begin
        int n;
        n_run = 0; n_fail = 0;
        rst_n0 = 1'b0; rst_n1 = 1'b0; ei_n0 = 1'b0; ei_n1 = 1'b0;
        key0 = -1; key1 = -1;
        kp0.ready = 1'b1; kp1.ready = 1'b1;
        fork monitor(); join_none

        repeat (3) @(negedge clk);
        chk("rst_y", 32'(y0), 32'hFF);
        chk("rst_a", 32'(a0), 32'd7);
        chk("rst_code", 32'(kp0.code), 32'd0);
        chk("rst_valid", 32'(kp0.valid), 32'd0);
        chk("rst_gs", 32'(gs0), 32'd1);

        // Open-key scan: 7F, BF, ... FE, 7F, four cycles each
        rst_n0 = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            chk("scan_y_valid_gs", 32'({y0, kp0.valid, gs0}),
                32'({onehot_n(3'(7 - k / 4)), 1'b0, 1'b1}));
        end

        // Key 5 with READY high
        key0 = 5; q0.push_back(3'd5);
        n = 0; while (gs0 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("k5_gs_lo", 32'(gs0), 32'd0);
        chk("k5_a", 32'(a0), 32'd5);
        chk("k5_y", 32'(y0), 32'hDF);
        n = 0; while (kp0.valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk("k5_valid", 32'({kp0.valid, kp0.code}), 32'({1'b1, 3'd5}));
        @(negedge clk);
        chk("k5_valid_1cyc", 32'(kp0.valid), 32'd0);
        chk("k5_release_gs", 32'(gs0), 32'd0);
        key0 = -1;
        n = 0; while (gs0 !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        chk("k5_gs_hi", 32'(gs0), 32'd1);
        chk("k5_resume_a", 32'(a0), 32'd4);

        // Bounce on key 2: abandoned confirm, scan continues at 1
        key0 = 2;
        n = 0; while (gs0 !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        chk("b2_gs_lo", 32'(gs0), 32'd0);
        chk("b2_a", 32'(a0), 32'd2);
        key0 = -1;
        n = 0; while (gs0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("b2_gs_hi", 32'(gs0), 32'd1);
        chk("b2_a_next", 32'(a0), 32'd1);
        chk("b2_no_valid", 32'(kp0.valid), 32'd0);

        // Key 6 with READY low for 20 cycles
        kp0.ready = 1'b0; key0 = 6; q0.push_back(3'd6);
        n = 0; while (kp0.valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("k6_valid", 32'(kp0.valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("k6_hold", 32'({kp0.valid, kp0.code}), 32'({1'b1, 3'd6}));
        end
        kp0.ready = 1'b1;
        @(negedge clk);
        kp0.ready = 1'b0;
        chk("k6_cleared", 32'(kp0.valid), 32'd0);
        chk("k6_release_gs", 32'(gs0), 32'd0);
        key0 = -1;
        n = 0; while (gs0 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("k6_gs_hi", 32'(gs0), 32'd1);
        chk("k6_resume_a", 32'(a0), 32'd5);

        // EI_N pulse during PRESENT discards the code
        key0 = 6;
        n = 0; while (kp0.valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("ei_valid", 32'(kp0.valid), 32'd1);
        ei_n0 = 1'b1;
        @(negedge clk);
        chk("ei_off", 32'({kp0.valid, y0, gs0, a0}), 32'({1'b0, 8'hFF, 1'b1, 3'd6}));
        key0 = -1; ei_n0 = 1'b0;
        @(negedge clk);
        chk("ei_resume_y", 32'({y0, gs0}), 32'({8'hBF, 1'b1}));
        chk("q0_empty", 32'(q0.size()), 32'd0);

        // DIV=1, DEBOUNCE=1: wrap with key open
        rst_n1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("d1_scan", 32'({a1, y1}), 32'({3'(7 - (k + 1)), onehot_n(3'(7 - k))}));
        end

        // Key 0 closed, READY high
        key1 = 0; q1.push_back(3'd0);
        n = 0; while (a1 !== 3'd0 && n < 20) begin @(negedge clk); n++; end
        chk("d1_at0", 32'({a1, kp1.valid, gs1}), 32'({3'd0, 1'b0, 1'b1}));
        @(negedge clk);
        chk("d1_valid", 32'({kp1.valid, kp1.code, a1, gs1}), 32'({1'b1, 3'd0, 3'd0, 1'b0}));
        @(negedge clk);
        chk("d1_taken", 32'(kp1.valid), 32'd0);
        key1 = -1;
        @(negedge clk);
        chk("d1_wrap", 32'({a1, gs1}), 32'({3'd7, 1'b1}));

        // Async reset in PRESENT
        kp1.ready = 1'b0; key1 = 3;
        n = 0; while (kp1.valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("d1_k3", 32'({kp1.valid, kp1.code}), 32'({1'b1, 3'd3}));
        #2 rst_n1 = 1'b0;
        #1;
        chk("d1_async_rst", 32'({y1, a1, kp1.code, kp1.valid, gs1}),
            32'({8'hFF, 3'd7, 3'd0, 1'b0, 1'b1}));
        chk("q1_empty", 32'(q1.size()), 32'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
